// File: rtl/pc_unit_pkg.sv
// Shared CPU definitions: branch condition codes, flag bit positions and the
// program-counter state encoding. Used by the fetch-stage PC unit and
// reusable by the execute-stage branch resolver.
package cpu_pkg;

    // Branch condition codes (ccc field)
    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OV     = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    // Bit positions inside the 3-bit {Z, V, N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_HALT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the pipeline controller and the PC unit.
// master: controller side (drives stall/halt/branch info, sees PC + status).
// slave : pc_unit side.
interface pc_unit_if #(
    parameter int ADDR_W = 16,
    parameter int IMM_W  = 9
);
    logic              stall;
    logic              halt_req;
    logic              br_valid;
    logic              br_reg;
    logic [2:0]        Condition;
    logic [IMM_W-1:0]  Imm;
    logic [2:0]        Flag;
    logic [ADDR_W-1:0] Rs_data;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] PC_addr;
    logic [ADDR_W-1:0] PC_plus;
    logic              taken;
    logic              flush;
    logic              halted;

    modport master (
        output stall, halt_req, br_valid, br_reg, Condition, Imm, Flag, Rs_data, br_pc,
        input  PC_addr, PC_plus, taken, flush, halted
    );

    modport slave (
        input  stall, halt_req, br_valid, br_reg, Condition, Imm, Flag, Rs_data, br_pc,
        output PC_addr, PC_plus, taken, flush, halted
    );
endinterface

// File: rtl/pc_unit_branch_cond_eval.sv
// Combinational branch condition evaluator.
// Ports: Condition (ccc code), Flag ({Z,V,N}) -> cond_met.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] Condition,
    input  logic [2:0] Flag,
    output logic       cond_met
);
    logic z, v, n;

    assign z = Flag[FLAG_Z];
    assign v = Flag[FLAG_V];
    assign n = Flag[FLAG_N];

    always_comb begin
        cond_met = 1'b0;
        unique case (Condition)
            CC_NE:     cond_met = ~z;
            CC_EQ:     cond_met = z;
            CC_GT:     cond_met = ~z & ~n;
            CC_LT:     cond_met = n;
            CC_GTE:    cond_met = z | (~z & ~n);
            CC_LTE:    cond_met = n | z;
            CC_OV:     cond_met = v;
            CC_UNCOND: cond_met = 1'b1;
            default:   cond_met = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program-counter unit.
// Holds the PC, produces the sequential next PC, resolves B/BR redirects and
// provides stall, halt and a registered one-cycle flush pulse.
// Ports: clk, rst (async, active high), bus (pc_unit_if.slave):
//   in : stall, halt_req, br_valid, br_reg, Condition, Imm, Flag, Rs_data, br_pc
//   out: PC_addr, PC_plus, taken, flush, halted
module pc_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W      = 16,
    parameter int              IMM_W       = 9,
    parameter int              INSTR_BYTES = 2,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic       clk,
    input  logic       rst,
    pc_unit_if.slave   bus
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus, imm_off, b_target, target;
    pc_state_e         state_q, state_d;
    logic              flush_q, flush_d;
    logic              cond_met, taken;

    branch_cond_eval u_cond (
        .Condition (bus.Condition),
        .Flag      (bus.Flag),
        .cond_met  (cond_met)
    );

    // Word offset -> byte offset: sign-extend and append a zero LSB.
    assign imm_off  = {{(ADDR_W-IMM_W-1){bus.Imm[IMM_W-1]}}, bus.Imm, 1'b0};
    assign pc_plus  = pc_q + ADDR_W'(INSTR_BYTES);
    // Relative to the instruction after the branch; overflow wraps silently.
    assign b_target = bus.br_pc + ADDR_W'(INSTR_BYTES) + imm_off;
    assign target   = bus.br_reg ? bus.Rs_data : b_target;

    assign taken = bus.br_valid & cond_met & (state_q == PC_RUN)
                 & ~bus.stall & ~bus.halt_req;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        flush_d = 1'b0;
        unique case (state_q)
            PC_RUN: begin
                if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.halt_req) begin
                    // PC parks on the HLT instruction itself
                    state_d = PC_HALT;
                end else if (taken) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                end else begin
                    pc_d = pc_plus;
                end
            end
            PC_HALT: begin
                pc_d = pc_q;
            end
            default: state_d = PC_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            state_q <= PC_RUN;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

    assign bus.PC_addr = pc_q;
    assign bus.PC_plus = pc_plus;
    assign bus.taken   = taken;
    assign bus.flush   = flush_q;
    assign bus.halted  = (state_q == PC_HALT);
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver pushes the expected observable
// state for each cycle, the monitor pops and compares on the falling edge.
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pc_unit_if #(.ADDR_W(16), .IMM_W(9)) bus ();

    pc_unit #(.ADDR_W(16), .IMM_W(9), .INSTR_BYTES(2), .RESET_VEC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] plus;
        logic        tk;
        logic        fl;
        logic        hl;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    // stimulus registers
    logic       s_rst, s_stall, s_hq, s_bv, s_brg;
    logic [2:0] s_cc, s_fl;
    logic [8:0] s_imm;
    logic [15:0] s_rs, s_bpc;

    // reference model state
    logic [15:0] m_pc;
    logic        m_flush, m_halt;

    function automatic bit ref_cond(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] ref_target();
        int t;
        if (s_brg) return s_rs;
        t = int'(s_bpc) + 2 + 2 * int'($signed(s_imm));
        return 16'(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        s_rst = 0; s_stall = 0; s_hq = 0; s_bv = 0; s_brg = 0;
        s_cc = 0; s_fl = 0; s_imm = 0; s_rs = 0; s_bpc = 0;
    endtask

    // Drive one cycle (just after a rising edge), record expectation, advance model.
    task automatic step();
        exp_t e;
        bit   tk;
        rst           = s_rst;
        bus.stall     = s_stall;
        bus.halt_req  = s_hq;
        bus.br_valid  = s_bv;
        bus.br_reg    = s_brg;
        bus.Condition = s_cc;
        bus.Imm       = s_imm;
        bus.Flag      = s_fl;
        bus.Rs_data   = s_rs;
        bus.br_pc     = s_bpc;
        if (s_rst) begin
            m_pc = 16'h0000; m_flush = 0; m_halt = 0;
        end
        tk = s_bv && ref_cond(s_cc, s_fl) && !m_halt && !s_stall && !s_hq;
        e.pc = m_pc; e.plus = m_pc + 16'd2; e.tk = tk; e.fl = m_flush; e.hl = m_halt;
        sb.push_back(e);
        if (!s_rst) begin
            if (m_halt)       m_flush = 0;
            else if (s_stall) m_flush = 0;
            else if (s_hq)    begin m_halt = 1; m_flush = 0; end
            else if (tk)      begin m_pc = ref_target(); m_flush = 1; end
            else              begin m_pc = m_pc + 16'd2; m_flush = 0; end
        end
        @(posedge clk); #1;
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("PC_addr", 32'(bus.PC_addr), 32'(e.pc));
                chk("PC_plus", 32'(bus.PC_plus), 32'(e.plus));
                chk("taken",   32'(bus.taken),   32'(e.tk));
                chk("flush",   32'(bus.flush),   32'(e.fl));
                chk("halted",  32'(bus.halted),  32'(e.hl));
            end
        end
    end

    initial begin
        idle();
        bus.stall = 0; bus.halt_req = 0; bus.br_valid = 0; bus.br_reg = 0;
        bus.Condition = 0; bus.Imm = 0; bus.Flag = 0; bus.Rs_data = 0; bus.br_pc = 0;
        m_pc = 16'h0000; m_flush = 0; m_halt = 0;
        repeat (2) @(posedge clk);
        #1;

        // reset release, sequential run, reset asserted mid-cycle
        repeat (4) step();
        s_rst = 1; step(); s_rst = 0;
        repeat (3) step();

        // GT taken vs not taken (N=1)
        s_bv = 1; s_cc = 3'b010; s_imm = 9'h004; s_bpc = 16'h0010; s_fl = 3'b000; step();
        idle(); step(); step();
        s_bv = 1; s_cc = 3'b010; s_imm = 9'h004; s_bpc = 16'h0010; s_fl = 3'b001; step();
        idle(); step();

        // BR, negative offset, wrap
        s_bv = 1; s_brg = 1; s_cc = 3'b111; s_rs = 16'h1234; step(); idle(); step();
        s_bv = 1; s_cc = 3'b111; s_imm = 9'h1FF; s_bpc = 16'h0020; step(); idle(); step();
        s_bv = 1; s_cc = 3'b111; s_imm = 9'h100; s_bpc = 16'h0000; step(); idle(); step();

        // stall priority at PC=0040
        s_bv = 1; s_brg = 1; s_cc = 3'b111; s_rs = 16'h0040; step(); idle();
        s_stall = 1; s_bv = 1; s_cc = 3'b111; s_imm = 9'h005; s_bpc = 16'h0040;
        step(); step();
        s_stall = 0; step(); idle(); step(); step();

        // halt at PC=0008 with simultaneous taken branch
        s_rst = 1; step(); s_rst = 0;
        repeat (4) step();
        s_hq = 1; s_bv = 1; s_cc = 3'b111; s_brg = 1; s_rs = 16'hBEEF; step();
        for (int i = 0; i < 10; i++) begin
            s_stall = 1'($urandom); s_hq = 1'($urandom); s_bv = 1'($urandom);
            s_brg = 1'($urandom); s_cc = 3'($urandom); s_fl = 3'($urandom);
            s_imm = 9'($urandom); s_rs = 16'($urandom); s_bpc = 16'($urandom);
            step();
        end
        idle(); s_rst = 1; step(); s_rst = 0; step();

        // full condition sweep
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                s_bv = 1; s_cc = 3'(c); s_fl = 3'(f); s_brg = 1'($urandom);
                s_imm = 9'($urandom); s_rs = 16'($urandom); s_bpc = 16'($urandom);
                step();
            end
        end

        // random soak
        idle();
        for (int i = 0; i < 150; i++) begin
            s_rst   = ($urandom_range(0, 19) == 0);
            s_stall = ($urandom_range(0, 3) == 0);
            s_hq    = ($urandom_range(0, 29) == 0);
            s_bv = 1'($urandom); s_brg = 1'($urandom); s_cc = 3'($urandom);
            s_fl = 3'($urandom); s_imm = 9'($urandom); s_rs = 16'($urandom);
            s_bpc = 16'($urandom);
            step();
        end
        idle(); step();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the fetch stage of the 16-bit pipeline.
- Holds the PC register and computes the sequential next PC.
- Evaluates the 3-bit branch condition against the flags, and redirects on PC-relative (B) or register (BR) branches.
- Adds stall, halt and a registered flush pulse, so the fetch/decode pipeline can be controlled without external glue.

Parameters:
- ADDR_W, 16, width of PC and of all addresses.
- IMM_W, 9, width of the signed branch immediate (word offset).
- INSTR_BYTES, 2, sequential increment in bytes.
- RESET_VEC, 16'h0000, PC value loaded on reset (ADDR_W wide).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC; all other requests ignored this cycle.
- halt_req  in  1  HLT decoded; enter HALT.
- br_valid  in  1  a branch instruction is present (decode stage).
- br_reg  in  1  1 = BR (target from Rs_data), 0 = B (PC-relative).
- Condition  in  3  branch condition code ccc.
- Imm  in  IMM_W  signed word offset for B.
- Flag  in  3  {Z, V, N} from the flag register.
- Rs_data  in  ADDR_W  register target for BR.
- br_pc  in  ADDR_W  address of the branch instruction.
- PC_addr  out  ADDR_W  current fetch address.
- PC_plus  out  ADDR_W  PC_addr + INSTR_BYTES, combinational.
- taken  out  1  combinational: branch resolves taken this cycle.
- flush  out  1  registered: one-cycle pulse the cycle after a taken redirect.
- halted  out  1  1 while in HALT.

Behaviour:
- Reset (async, any time, including mid-branch or in HALT): PC_addr=RESET_VEC, state=RUN, flush=0, halted=0. PC_plus=RESET_VEC+INSTR_BYTES follows from the PC.
- Flag decode: Z=Flag[2], V=Flag[1], N=Flag[0].
- Condition met, by ccc:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or (Z=0 and N=0)
  - 101 LTE: N=1 or Z=1
  - 110 OV: V=1
  - 111 unconditional
- taken = br_valid & cond_met & state==RUN & ~stall & ~halt_req.
- Targets:
  - B target = br_pc + INSTR_BYTES + (sign_extend(Imm) << 1), modulo 2^ADDR_W; wrap-around is silent, no error.
  - BR target = Rs_data; bit 0 is not masked.
- States:
  - RUN: normal operation.
  - HALT: PC frozen, halted=1. Left only by rst.
- Next-state/next-PC priority, evaluated per rising edge while in RUN:
  1. stall=1 -> PC holds, flush<=0, state unchanged. Upstream holds branch inputs stable across the stall.
  2. halt_req=1 -> PC holds at the HLT address, state<=HALT, flush<=0. A simultaneous branch is ignored.
  3. taken=1 -> PC<=target, flush<=1.
  4. otherwise -> PC<=PC_plus, flush<=0.
- Branch timing:
  - Latency from taken to new PC_addr: 1 cycle.
  - flush is high in exactly the cycle where PC_addr first shows the target.
  - Back-to-back taken branches produce back-to-back flush cycles.
- HALT: stall, halt_req and branch inputs are all ignored; taken=0, flush=0.
- PC_plus at the top of the address space wraps: FFFE+2=0000.

Decomposition:
- Shared package (cpu_pkg):
  - condition-code constants CC_NE..CC_UNCOND
  - flag bit indices FLAG_Z/FLAG_V/FLAG_N
  - state enum {PC_RUN, PC_HALT}
- One combinational sub-module, branch_cond_eval (Condition, Flag -> cond_met).
  - Reusable by the execute-stage branch resolver.
- The PC register, state flop, flush flop and target adders live in pc_unit.

Test Plan:
- Reset/sequential: assert rst mid-cycle, release -> PC_addr=0000 immediately; then 0002, 0004, 0006 on successive edges; flush=0, halted=0.
- Conditional B, GT vs LT:
  - br_pc=0010, Imm=9'h004, Condition=010, Flag={0,0,0} -> taken=1; next PC_addr=001A, flush=1 for one cycle.
  - Same inputs but Flag={0,0,1} -> taken=0, PC_addr=PC_plus.
- BR and negative offset:
  - br_reg=1, Condition=111, Rs_data=1234 -> PC_addr=1234.
  - B with Imm=9'h1FF at br_pc=0020 -> PC_addr=0020.
  - B with Imm=9'h100 at br_pc=0000 -> PC_addr=FE02 (wrap).
- Stall priority: at PC=0040, stall=1 together with a taken branch -> PC stays 0040, taken=0, flush=0. Release stall with branch held -> redirect on the next edge.
- Halt:
  - halt_req=1 at PC=0008 together with a taken branch -> PC stays 0008, halted=1 from the next cycle, and stays there for 10 cycles of random branch/stall inputs.
  - rst -> PC_addr=0000, halted=0.
- Full condition sweep: all 8 ccc x 8 flag combinations -> taken matches the condition table exactly (64 checks).
